dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arb_rr.sv | 28 ++
 rtl/dmem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants and helpers for the data-memory arbiter.
// Latency: n/a (types, constants and functions only).
// Backpressure: n/a.
package dmem_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;
    localparam int CW_DEF = 16;

    // Requester indices: CPU load/store unit and debug/DMA port
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // All-ones value of a cw-bit counter, where the statistics counters stop
    function automatic logic [63:0] cnt_sat_max(input int unsigned cw);
        if (cw >= 64) begin
            return '1;
        end
        return (64'd1 << cw) - 64'd1;
    endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin pick with lock override; one-hot (or zero) grant vector.
// Latency: purely combinational, same-cycle grant.
// Backpressure: a locked owner masks the other port; the losing requester simply sees gnt=0.
module dmem_arb_rr (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       lock_i,
    input  logic       owner_i,
    output logic [1:0] gnt_o
);

    // While locked only the owner may win; otherwise a tie goes to the port not served last
    always_comb begin
        gnt_o = 2'b00;
        if (lock_i) begin
            if (owner_i) begin
                gnt_o[1] = req_i[1];
            end else begin
                gnt_o[0] = req_i[0];
            end
        end else if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU (port 0) and debug/DMA (port 1) onto a single-port synchronous dmem.
// Latency: grant and mem command are combinational; read data returns with rvalid one cycle later.
// Backpressure: losing or locked-out requester holds its request until gnt; optional DMEM_ARB_STATS_EN adds grant counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          p0_req_i,
    input  logic          p0_we_i,
    input  logic          p0_lock_i,
    input  logic [AW-1:0] p0_addr_i,
    input  logic [DW-1:0] p0_wdata_i,
    output logic          p0_gnt_o,
    output logic          p0_rvalid_o,
    output logic [DW-1:0] p0_rdata_o,

    input  logic          p1_req_i,
    input  logic          p1_we_i,
    input  logic          p1_lock_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [DW-1:0] p1_wdata_i,
    output logic          p1_gnt_o,
    output logic          p1_rvalid_o,
    output logic [DW-1:0] p1_rdata_o,

    output logic          mem_read_o,
    output logic          mem_write_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,

    output logic [CW-1:0] p0_cnt_o,
    output logic [CW-1:0] p1_cnt_o
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       gnt_any;
    logic       sel;
    logic       sel_we;
    logic       sel_lock;

    logic last_q, last_d;
    logic lock_q, lock_d;
    logic owner_q, owner_d;
    logic rd_pend_q, rd_pend_d;
    logic rd_src_q, rd_src_d;

    assign req = {p1_req_i, p0_req_i};

    dmem_arb_rr u_rr (
        .req_i   (req),
        .last_i  (last_q),
        .lock_i  (lock_q),
        .owner_i (owner_q),
        .gnt_o   (gnt)
    );

    assign p0_gnt_o = gnt[0];
    assign p1_gnt_o = gnt[1];
    assign gnt_any  = |gnt;
    // gnt is one-hot, so bit 1 alone identifies the winner
    assign sel      = gnt[1];

    // Steer the winning port onto the memory; everything idles at zero without a grant
    always_comb begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        sel_we      = 1'b0;
        sel_lock    = 1'b0;
        if (gnt[0]) begin
            sel_we      = p0_we_i;
            sel_lock    = p0_lock_i;
            mem_write_o = p0_we_i;
            mem_read_o  = ~p0_we_i;
            mem_addr_o  = p0_addr_i;
            mem_wdata_o = p0_wdata_i;
        end else if (gnt[1]) begin
            sel_we      = p1_we_i;
            sel_lock    = p1_lock_i;
            mem_write_o = p1_we_i;
            mem_read_o  = ~p1_we_i;
            mem_addr_o  = p1_addr_i;
            mem_wdata_o = p1_wdata_i;
        end
    end

    // Next-state for fairness pointer, lock ownership and the pending read return
    always_comb begin
        last_d    = last_q;
        lock_d    = lock_q;
        owner_d   = owner_q;
        rd_pend_d = gnt_any & ~sel_we;
        rd_src_d  = rd_src_q;
        if (gnt_any) begin
            last_d   = sel;
            rd_src_d = sel;
        end
        // An owner that stops requesting abandons the lock, even mid-sequence
        if (lock_q && !req[owner_q]) begin
            lock_d = 1'b0;
        end else if (gnt_any) begin
            lock_d = sel_lock;
            if (sel_lock) begin
                owner_d = sel;
            end
        end
    end

    // Arbiter state; reset hands the first tie to the CPU port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= PORT_DBG;
            lock_q    <= 1'b0;
            owner_q   <= PORT_CPU;
            rd_pend_q <= 1'b0;
            rd_src_q  <= PORT_CPU;
        end else begin
            last_q    <= last_d;
            lock_q    <= lock_d;
            owner_q   <= owner_d;
            rd_pend_q <= rd_pend_d;
            rd_src_q  <= rd_src_d;
        end
    end

    // dmem already registers its read, so data is passed straight through and qualified by rvalid
    assign p0_rvalid_o = rd_pend_q & (rd_src_q == PORT_CPU);
    assign p1_rvalid_o = rd_pend_q & (rd_src_q == PORT_DBG);
    assign p0_rdata_o  = mem_rdata_i;
    assign p1_rdata_o  = mem_rdata_i;

`ifdef DMEM_ARB_STATS_EN
    localparam logic [CW-1:0] CNT_MAX = CW'(cnt_sat_max(CW));

    logic [CW-1:0] p0_cnt_q, p0_cnt_d;
    logic [CW-1:0] p1_cnt_q, p1_cnt_d;

    // Per-port grant counts, holding at all-ones instead of wrapping
    always_comb begin
        p0_cnt_d = p0_cnt_q;
        p1_cnt_d = p1_cnt_q;
        if (gnt[0] && (p0_cnt_q != CNT_MAX)) begin
            p0_cnt_d = p0_cnt_q + CW'(1);
        end
        if (gnt[1] && (p1_cnt_q != CNT_MAX)) begin
            p1_cnt_d = p1_cnt_q + CW'(1);
        end
    end

    // Counters clear only on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_cnt_q <= '0;
            p1_cnt_q <= '0;
        end else begin
            p0_cnt_q <= p0_cnt_d;
            p1_cnt_q <= p1_cnt_d;
        end
    end

    assign p0_cnt_o = p0_cnt_q;
    assign p1_cnt_o = p1_cnt_q;
`else
    assign p0_cnt_o = '0;
    assign p1_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dmem and a read-return scoreboard.
// Latency: expects read data exactly one cycle after each read grant.
// Backpressure: requesters hold their request until granted, as a real master would.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
    logic [7:0]  p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
    logic [7:0]  p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [1:0]  p0_cnt, p1_cnt;

    logic [31:0] dmem   [256];
    logic [31:0] shadow [256];
    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;

    dmem_arbiter #(.AW(8), .DW(32), .CW(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p0_req_i    (p0_req),
        .p0_we_i     (p0_we),
        .p0_lock_i   (p0_lock),
        .p0_addr_i   (p0_addr),
        .p0_wdata_i  (p0_wdata),
        .p0_gnt_o    (p0_gnt),
        .p0_rvalid_o (p0_rvalid),
        .p0_rdata_o  (p0_rdata),
        .p1_req_i    (p1_req),
        .p1_we_i     (p1_we),
        .p1_lock_i   (p1_lock),
        .p1_addr_i   (p1_addr),
        .p1_wdata_i  (p1_wdata),
        .p1_gnt_o    (p1_gnt),
        .p1_rvalid_o (p1_rvalid),
        .p1_rdata_o  (p1_rdata),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .p0_cnt_o    (p0_cnt),
        .p1_cnt_o    (p1_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return {a, a, a, a} ^ 32'hA5A5_0F0F;
    endfunction

    // Single-port synchronous dmem: write and registered read at the clock edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) dmem[i] <= init_val(8'(i));
            mem_rdata <= '0;
        end else begin
            if (mem_write) dmem[mem_addr] <= mem_wdata;
            if (mem_read)  mem_rdata <= dmem[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic drv0(input logic r, input logic w, input logic l,
                        input logic [7:0] a, input logic [31:0] d);
        p0_req = r; p0_we = w; p0_lock = l; p0_addr = a; p0_wdata = d;
    endtask

    task automatic drv1(input logic r, input logic w, input logic l,
                        input logic [7:0] a, input logic [31:0] d);
        p1_req = r; p1_we = w; p1_lock = l; p1_addr = a; p1_wdata = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drv0(0, 0, 0, 8'h00, 32'h0);
        drv1(0, 0, 0, 8'h00, 32'h0);
        sb.delete();
        for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.rv0",  {31'b0, p0_rvalid}, 32'd0);
        chk("rst.rv1",  {31'b0, p1_rvalid}, 32'd0);
        chk("rst.gnt0", {31'b0, p0_gnt},    32'd0);
        chk("rst.gnt1", {31'b0, p1_gnt},    32'd0);
        chk("rst.mrd",  {31'b0, mem_read},  32'd0);
        chk("rst.mwr",  {31'b0, mem_write}, 32'd0);
        chk("rst.madr", {24'b0, mem_addr},  32'd0);
        chk("rst.cnt0", {30'b0, p0_cnt},    32'd0);
        chk("rst.cnt1", {30'b0, p1_cnt},    32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock of directed stimulus: check read return, grants and mem command, then score the grant
    task automatic cycle(input logic eg0, input logic eg1, input string tag, input bit rst_mid = 1'b0);
        exp_t        e;
        logic        erv0, erv1, emw, emr;
        logic [31:0] ed, ewd;
        logic [7:0]  ea;
        erv0 = 1'b0; erv1 = 1'b0; ed = '0;
        @(negedge clk);
        if (sb.size() > 0) begin
            e    = sb.pop_front();
            erv0 = ~e.port;
            erv1 = e.port;
            ed   = e.data;
        end
        chk({tag, ".rv0"}, {31'b0, p0_rvalid}, {31'b0, erv0});
        chk({tag, ".rv1"}, {31'b0, p1_rvalid}, {31'b0, erv1});
        if (erv0) chk({tag, ".rd0"}, p0_rdata, ed);
        if (erv1) chk({tag, ".rd1"}, p1_rdata, ed);
        chk({tag, ".gnt0"}, {31'b0, p0_gnt}, {31'b0, eg0});
        chk({tag, ".gnt1"}, {31'b0, p1_gnt}, {31'b0, eg1});
        emw = (eg0 & p0_we)  | (eg1 & p1_we);
        emr = (eg0 & ~p0_we) | (eg1 & ~p1_we);
        ea  = eg0 ? p0_addr  : (eg1 ? p1_addr  : 8'h00);
        ewd = eg0 ? p0_wdata : (eg1 ? p1_wdata : 32'h0);
        chk({tag, ".mwr"},  {31'b0, mem_write}, {31'b0, emw});
        chk({tag, ".mrd"},  {31'b0, mem_read},  {31'b0, emr});
        chk({tag, ".madr"}, {24'b0, mem_addr},  {24'b0, ea});
        chk({tag, ".mwd"},  mem_wdata, ewd);
        if (rst_mid) begin
            rst_n = 1'b0;
            sb.delete();
            #1;
            chk({tag, ".arst_rv0"}, {31'b0, p0_rvalid}, 32'd0);
            chk({tag, ".arst_rv1"}, {31'b0, p1_rvalid}, 32'd0);
        end else begin
            if (eg0) begin
                if (p0_we) shadow[p0_addr] = p0_wdata;
                else       sb.push_back(exp_t'{port: 1'b0, data: shadow[p0_addr]});
            end
            if (eg1) begin
                if (p1_we) shadow[p1_addr] = p1_wdata;
                else       sb.push_back(exp_t'{port: 1'b1, data: shadow[p1_addr]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();

        // Write then read-back on the CPU port
        drv0(1, 1, 0, 8'h10, 32'hDEAD_BEEF);
        cycle(1, 0, "wr10");
        drv0(1, 0, 0, 8'h10, 32'h0);
        cycle(1, 0, "rd10");
        drv0(0, 0, 0, 8'h00, 32'h0);
        cycle(0, 0, "rd10ret");

        // Serve port 1 once so the next tie favours port 0, then alternate under contention
        drv1(1, 0, 0, 8'h30, 32'h0);
        cycle(0, 1, "p1rd30");
        drv0(1, 0, 0, 8'h40, 32'h0);
        drv1(1, 0, 0, 8'h41, 32'h0);
        cycle(1, 0, "rr0");
        drv0(1, 0, 0, 8'h42, 32'h0);
        cycle(0, 1, "rr1");
        drv1(1, 0, 0, 8'h43, 32'h0);
        cycle(1, 0, "rr2");
        drv0(1, 0, 0, 8'h44, 32'h0);
        cycle(0, 1, "rr3");
        drv1(0, 0, 0, 8'h00, 32'h0);
        cycle(1, 0, "rr4");

        // Locked read-modify-write by port 1 while port 0 keeps asking
        drv0(1, 0, 0, 8'h50, 32'h0);
        drv1(1, 0, 1, 8'h20, 32'h0);
        cycle(0, 1, "lk_rd");
        drv1(1, 1, 0, 8'h20, 32'h1234_5678);
        cycle(0, 1, "lk_wr");
        drv1(0, 0, 0, 8'h00, 32'h0);
        cycle(1, 0, "lk_after");
        drv0(0, 0, 0, 8'h00, 32'h0);
        drv1(1, 0, 0, 8'h20, 32'h0);
        cycle(0, 1, "rd20");

        // Owner abandons the lock by dropping its request
        drv1(1, 0, 1, 8'h60, 32'h0);
        cycle(0, 1, "ab_lk");
        drv1(0, 0, 0, 8'h00, 32'h0);
        drv0(1, 0, 0, 8'h61, 32'h0);
        cycle(0, 0, "ab_drop");
        cycle(1, 0, "ab_p0");

        // Reset lands while a locked read is in flight
        drv0(0, 0, 0, 8'h00, 32'h0);
        drv1(1, 0, 1, 8'h20, 32'h0);
        cycle(0, 1, "rs_lk");
        drv1(1, 0, 1, 8'h21, 32'h0);
        cycle(0, 1, "rs_rd", 1'b1);
        do_reset();
        drv0(1, 0, 0, 8'h10, 32'h0);
        drv1(1, 0, 0, 8'h11, 32'h0);
        cycle(1, 0, "rs_tie");
        drv0(0, 0, 0, 8'h00, 32'h0);
        cycle(0, 1, "rs_p1");
        drv1(0, 0, 0, 8'h00, 32'h0);
        cycle(0, 0, "rs_drain");

        // Grant counters: count, then saturate at 3 for a 2-bit counter
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drv0(1, 1, 0, 8'(8'h70 + k), 32'(k));
            cycle(1, 0, "cnt_a");
        end
        chk("cnt_mid0", {30'b0, p0_cnt}, STATS ? 32'd2 : 32'd0);
        for (int k = 2; k < 5; k++) begin
            drv0(1, 1, 0, 8'(8'h70 + k), 32'(k));
            cycle(1, 0, "cnt_b");
        end
        drv0(0, 0, 0, 8'h00, 32'h0);
        cycle(0, 0, "cnt_idle");
        chk("cnt_sat0", {30'b0, p0_cnt}, STATS ? 32'd3 : 32'd0);
        chk("cnt_p1",   {30'b0, p1_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
